red_diamond_controller: RTL and testbench
=========================================

// Module: red_diamond_controller
// PURPOSE
//  Upstream stage of the red-diamond sprite renderer. Produces the diamond centre (x_d, y_d) with
//  a per-frame vertical bob, plus a visibility flag that gates the renderer's pixel mux.
//  Detects Fireboy overlap, runs a short collect animation, then hides the diamond.
//  Pulses collect_pulse once for the score logic. One instance per diamond on the level.
// PARAMETERS
//  X_INIT       10'd320  diamond centre X (pixels); constant, driven straight to x_d
//  Y_INIT       10'd240  diamond rest centre Y (pixels)
//  HALF_SIZE    10       diamond half-extent (sprite is 20x20)
//  PLAYER_HALF  12       Fireboy hitbox half-extent
//  BOB_AMPL     3        bob amplitude in pixels, >=1; y_d spans Y_INIT-BOB_AMPL..Y_INIT+BOB_AMPL
//  COLLECT_FRM  8        frames spent in COLLECTING, >=1
// PORTS
//  vga_clk        in   1   pixel clock; only clock
//  reset_n        in   1   synchronous, active-low reset
//  vsync          in   1   VGA vsync, active low; a falling edge marks a frame tick
//  level_start    in   1   synchronous respawn: back to VISIBLE, bob phase 0
//  fb_x, fb_y     in   10  Fireboy centre (pixels); sampled only on a frame tick
//  x_d, y_d       out  10  diamond centre to the renderer
//  diamond_on     out  1   renderer enable (1 = draw the sprite)
//  collect_pulse  out  1   one vga_clk pulse when a collection is accepted
//  collected      out  1   sticky; high from the VISIBLE->COLLECTING transition until respawn
// BEHAVIOUR
//  Reset (reset_n=0 at a clock edge): state=VISIBLE, phase=0, vs_q=1, x_d=X_INIT, y_d=Y_INIT,
//    diamond_on=1, collect_pulse=0, collected=0, frame count=0.
//  Frame tick: vs_q <= vsync; tick = vs_q & ~vsync. Tick is combinational and acts in the same cycle.
//  Bob: phase counts 0..4*BOB_AMPL-1 and wraps to 0; it advances on every tick in every state.
//    off = p<A ? p : (p<3A ? 2A-p : p-4A), A=BOB_AMPL, signed 11-bit.
//    y_d <= Y_INIT+off, registered on the tick cycle, so it is visible 1 clk after the tick.
//    Out-of-range values are the user's problem; no clamping.
//  Hit test on a tick in VISIBLE:
//    |fb_x-X_INIT| < HALF_SIZE+PLAYER_HALF AND |fb_y-y_d| < HALF_SIZE+PLAYER_HALF.
//    Use the current (pre-update) y_d. Differences are 11-bit signed, strict less-than.
//  FSM:
//    VISIBLE    -- hit on tick --> COLLECTING: collect_pulse=1 for 1 clk, collected<=1, cnt<=0.
//    COLLECTING -- each tick --> cnt+1; when cnt reaches COLLECT_FRM-1 on a tick --> GONE.
//    GONE: diamond_on=0; ignores fb_x/fb_y; phase keeps running.
//  level_start=1: state<=VISIBLE, phase<=0, y_d<=Y_INIT, collected<=0, diamond_on<=1, cnt<=0.
//    It overrides a simultaneous tick and a simultaneous hit, so no collect_pulse.
//    It is legal in any state, including mid-COLLECTING.
//  reset_n has priority over level_start.
//  collect_pulse never asserts twice without an intervening level_start or reset.
//  All outputs are registered.
// CONFIGURATION
//  DIAMOND_FLASH_EN defined:
//    in COLLECTING, diamond_on toggles on every tick, starting at 0 on the first tick after entry;
//    it is 1 on the entry cycle.
//  DIAMOND_FLASH_EN undefined:
//    diamond_on<=0 on the same edge that enters COLLECTING; the COLLECTING timing is unchanged.
//  In both builds, diamond_on=0 in GONE.
// TESTING
//  1 Reset, A=3: 12 vsync falling edges -> y_d = 241,242,243,242,241,240,239,238,237,238,239,240; x_d=320 throughout.
//  2 fb=(320,240) before tick 1 -> collect_pulse high exactly 1 clk, collected=1;
//    GONE after tick 8 of COLLECTING; diamond_on=0.
//  3 fb=(342,240) (dx=22) -> no hit; fb=(341,240) -> hit. Boundary check at HALF_SIZE+PLAYER_HALF.
//  4 level_start asserted on the same clk as a hit tick -> no collect_pulse, state VISIBLE, y_d=240.
//  5 level_start during COLLECTING cnt=4 -> VISIBLE, collected=0, diamond_on=1;
//    a later re-hit gives a second pulse.
//  6 FLASH_EN build: diamond_on over the COLLECTING ticks = 1(entry),0,1,0,1,0,1,0 then 0 in GONE;
//    non-FLASH build: 0 from entry.

Source files
------------

// File: rtl/red_diamond_controller.sv
// red_diamond_controller
//   Upstream stage of the red-diamond sprite renderer. It produces the diamond
//   centre with a per-frame vertical bob and a visibility flag for the pixel
//   mux. When Fireboy overlaps the diamond it pulses collect_pulse once, runs a
//   short collect animation, then hides the diamond until level_start.
//
//   Optional feature macro: DIAMOND_FLASH_EN
//     defined   : diamond_on blinks once per frame while collecting
//     undefined : diamond_on drops as soon as the collection is accepted
//
// Ports
//   vga_clk        in   pixel clock, the only clock
//   reset_n        in   synchronous active-low reset (priority over level_start)
//   vsync          in   VGA vsync, active low; a falling edge is a frame tick
//   level_start    in   synchronous respawn to VISIBLE with bob phase 0
//   fb_x, fb_y     in   Fireboy centre, used only on a frame tick
//   x_d, y_d       out  diamond centre
//   diamond_on     out  renderer enable
//   collect_pulse  out  one-clock pulse when a collection is accepted
//   collected      out  sticky collected flag, cleared by respawn
module red_diamond_controller #(
  parameter logic [9:0] X_INIT      = 10'd320,
  parameter logic [9:0] Y_INIT      = 10'd240,
  parameter int         HALF_SIZE   = 10,
  parameter int         PLAYER_HALF = 12,
  parameter int         BOB_AMPL    = 3,
  parameter int         COLLECT_FRM = 8
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       level_start,
  input  logic [9:0] fb_x,
  input  logic [9:0] fb_y,
  output logic [9:0] x_d,
  output logic [9:0] y_d,
  output logic       diamond_on,
  output logic       collect_pulse,
  output logic       collected
);

  localparam int PW = $clog2(4 * BOB_AMPL);
  localparam int CW = (COLLECT_FRM > 1) ? $clog2(COLLECT_FRM) : 1;

  localparam logic [PW-1:0]     PH_LAST  = PW'(4 * BOB_AMPL - 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(COLLECT_FRM - 1);
  localparam logic signed [10:0] A1      = 11'(BOB_AMPL);
  localparam logic signed [10:0] A2      = 11'(2 * BOB_AMPL);
  localparam logic signed [10:0] A3      = 11'(3 * BOB_AMPL);
  localparam logic signed [10:0] A4      = 11'(4 * BOB_AMPL);
  localparam logic [10:0]        HIT_LIM = 11'(HALF_SIZE + PLAYER_HALF);

`ifdef DIAMOND_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  typedef enum logic [1:0] {VISIBLE, COLLECTING, GONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase, phase_nxt, phase_inc;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          vs_q;
  logic [9:0]    y_nxt, y_tick;
  logic          on_nxt, pulse_nxt, coll_nxt;
  logic          tick, hit;

  // Triangle wave: 0 -> +A -> 0 -> -A -> 0 over 4A phases.
  function automatic logic signed [10:0] bob_off(input logic [PW-1:0] p);
    logic signed [10:0] ps;
    ps = signed'(11'(p));
    if (ps < A1)      return ps;
    else if (ps < A3) return A2 - ps;
    else              return ps - A4;
  endfunction

  logic signed [10:0] ysum, dx, dy;
  logic [10:0]        adx, ady;

  assign tick      = vs_q & ~vsync;
  assign phase_inc = (phase == PH_LAST) ? '0 : phase + PW'(1);
  // y_d follows the phase it is about to take, so it lands one clock after the tick.
  assign ysum      = signed'({1'b0, Y_INIT}) + bob_off(phase_inc);
  assign y_tick    = ysum[9:0];

  // Hit test against the y_d currently on screen (pre-update).
  assign dx  = signed'({1'b0, fb_x}) - signed'({1'b0, X_INIT});
  assign dy  = signed'({1'b0, fb_y}) - signed'({1'b0, y_d});
  assign adx = dx[10] ? 11'(-dx) : 11'(dx);
  assign ady = dy[10] ? 11'(-dy) : 11'(dy);
  assign hit = (adx < HIT_LIM) && (ady < HIT_LIM);

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    cnt_nxt   = cnt;
    y_nxt     = y_d;
    on_nxt    = diamond_on;
    pulse_nxt = 1'b0;
    coll_nxt  = collected;
    if (level_start) begin
      // Respawn wins over any tick or hit in the same cycle.
      state_nxt = VISIBLE;
      phase_nxt = '0;
      cnt_nxt   = '0;
      y_nxt     = Y_INIT;
      on_nxt    = 1'b1;
      coll_nxt  = 1'b0;
    end else if (tick) begin
      phase_nxt = phase_inc;
      y_nxt     = y_tick;
      case (state)
        VISIBLE: begin
          if (hit) begin
            state_nxt = COLLECTING;
            cnt_nxt   = '0;
            pulse_nxt = 1'b1;
            coll_nxt  = 1'b1;
            on_nxt    = FLASH;
          end
        end
        COLLECTING: begin
          if (cnt == CNT_LAST) begin
            state_nxt = GONE;
            on_nxt    = 1'b0;
          end else begin
            cnt_nxt = cnt + CW'(1);
            on_nxt  = FLASH ? ~diamond_on : 1'b0;
          end
        end
        default: on_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state         <= VISIBLE;
      phase         <= '0;
      cnt           <= '0;
      vs_q          <= 1'b1;
      x_d           <= X_INIT;
      y_d           <= Y_INIT;
      diamond_on    <= 1'b1;
      collect_pulse <= 1'b0;
      collected     <= 1'b0;
    end else begin
      state         <= state_nxt;
      phase         <= phase_nxt;
      cnt           <= cnt_nxt;
      vs_q          <= vsync;
      x_d           <= X_INIT;
      y_d           <= y_nxt;
      diamond_on    <= on_nxt;
      collect_pulse <= pulse_nxt;
      collected     <= coll_nxt;
    end
  end

endmodule

// File: tb/tb_red_diamond_controller.sv
module tb_red_diamond_controller;

  logic       clk = 1'b0;
  logic       reset_n, vsync, level_start;
  logic [9:0] fb_x, fb_y, x_d, y_d;
  logic       diamond_on, collect_pulse, collected;

  always #5 clk = ~clk;

  red_diamond_controller dut (
    .vga_clk(clk), .reset_n(reset_n), .vsync(vsync), .level_start(level_start),
    .fb_x(fb_x), .fb_y(fb_y), .x_d(x_d), .y_d(y_d), .diamond_on(diamond_on),
    .collect_pulse(collect_pulse), .collected(collected)
  );

`ifdef DIAMOND_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  typedef struct {
    int fx, fy;
    bit ls, tk;
    int y;
    bit on_n, on_f, pulse, coll;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int fx, fy, input bit ls, tk, input int y,
                     input bit on_n, on_f, pulse, coll);
    vec_t v;
    v.fx = fx; v.fy = fy; v.ls = ls; v.tk = tk; v.y = y;
    v.on_n = on_n; v.on_f = on_f; v.pulse = pulse; v.coll = coll;
    vecs.push_back(v);
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    fb_x = 10'(v.fx); fb_y = 10'(v.fy);
    level_start = v.ls;
    vsync = v.tk ? 1'b0 : 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk($sformatf("row%0d_sb_empty", idx), 0, 1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("row%0d_y", idx), int'(y_d), e.y);
      chk($sformatf("row%0d_x", idx), int'(x_d), 320);
      chk($sformatf("row%0d_on", idx), int'(diamond_on), FLASH ? int'(e.on_f) : int'(e.on_n));
      chk($sformatf("row%0d_pulse", idx), int'(collect_pulse), int'(e.pulse));
      chk($sformatf("row%0d_coll", idx), int'(collected), int'(e.coll));
    end
    @(negedge clk);
    vsync = 1'b1; level_start = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("row%0d_pulse_drop", idx), int'(collect_pulse), 0);
  endtask

  initial begin
    int ybob[12];
    ybob = '{241, 242, 243, 242, 241, 240, 239, 238, 237, 238, 239, 240};
    // bob sequence from reset, Fireboy far away
    for (int i = 0; i < 12; i++) add(0, 0, 0, 1, ybob[i], 1, 1, 0, 0);
    // dx=22 misses, dx=21 hits (y_d pre-update 241)
    add(342, 240, 0, 1, 241, 1, 1, 0, 0);
    add(341, 240, 0, 1, 242, 0, 1, 1, 1);
    // eight COLLECTING ticks, GONE on the eighth
    add(0, 0, 0, 1, 243, 0, 0, 0, 1);
    add(0, 0, 0, 1, 242, 0, 1, 0, 1);
    add(0, 0, 0, 1, 241, 0, 0, 0, 1);
    add(0, 0, 0, 1, 240, 0, 1, 0, 1);
    add(0, 0, 0, 1, 239, 0, 0, 0, 1);
    add(0, 0, 0, 1, 238, 0, 1, 0, 1);
    add(0, 0, 0, 1, 237, 0, 0, 0, 1);
    add(0, 0, 0, 1, 238, 0, 0, 0, 1);
    // GONE ignores an overlapping Fireboy
    add(320, 238, 0, 1, 239, 0, 0, 0, 1);
    // respawn, hit at rest position, abort at cnt=4, re-hit
    add(0, 0, 1, 0, 240, 1, 1, 0, 0);
    add(320, 240, 0, 1, 241, 0, 1, 1, 1);
    add(0, 0, 0, 1, 242, 0, 0, 0, 1);
    add(0, 0, 0, 1, 243, 0, 1, 0, 1);
    add(0, 0, 0, 1, 242, 0, 0, 0, 1);
    add(0, 0, 0, 1, 241, 0, 1, 0, 1);
    add(0, 0, 1, 0, 240, 1, 1, 0, 0);
    add(320, 240, 0, 1, 241, 0, 1, 1, 1);
    // level_start with a simultaneous hit tick
    add(0, 0, 1, 0, 240, 1, 1, 0, 0);
    add(320, 240, 1, 1, 240, 1, 1, 0, 0);
    add(0, 0, 0, 1, 241, 1, 1, 0, 0);

    reset_n = 1'b0; vsync = 1'b1; level_start = 1'b0; fb_x = '0; fb_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_y", int'(y_d), 240);
    chk("reset_x", int'(x_d), 320);
    chk("reset_on", int'(diamond_on), 1);
    chk("reset_pulse", int'(collect_pulse), 0);
    chk("reset_coll", int'(collected), 0);
    @(negedge clk); reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
    chk("sb_drained", sb.size(), 0);

    // vsync held low: only the falling edge ticks
    @(negedge clk); vsync = 1'b0;
    @(posedge clk); #1;
    chk("hold_low_first", int'(y_d), 242);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_low_stays", int'(y_d), 242);
    @(negedge clk); vsync = 1'b1;
    @(posedge clk);

    // enter COLLECTING, then reset beats level_start
    @(negedge clk); fb_x = 10'd320; fb_y = 10'd242; vsync = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_pulse", int'(collect_pulse), 1);
    @(negedge clk); vsync = 1'b1; reset_n = 1'b0; level_start = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_y", int'(y_d), 240);
    chk("mid_reset_on", int'(diamond_on), 1);
    chk("mid_reset_coll", int'(collected), 0);
    @(negedge clk); reset_n = 1'b1; level_start = 1'b0; fb_x = '0; fb_y = '0;
    @(negedge clk); vsync = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_y", int'(y_d), 241);
    @(negedge clk); vsync = 1'b1;
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
